// File: rtl/voxel_ram_arbiter.sv
`default_nettype none
// voxel_ram_arbiter: one single-port voxel RAM shared by NUM_REQ round-robin readers and a
// burst-limited priority writer, with fixed-latency read return. Revision 1.0
module voxel_ram_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 5,
  parameter int RAM_LATENCY  = 2,
  parameter int WR_BURST_MAX = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        rd_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr_in,
  output logic [NUM_REQ-1:0]        rd_ready_out,
  output logic [NUM_REQ-1:0]        rsp_valid_out,
  output logic [DATA_W-1:0]         rsp_data_out,
  input  logic                      wr_valid_in,
  input  logic [ADDR_W-1:0]         wr_addr_in,
  input  logic [DATA_W-1:0]         wr_data_in,
  output logic                      wr_ready_out,
  output logic                      ram_en_out,
  output logic                      ram_we_out,
  output logic [ADDR_W-1:0]         ram_addr_out,
  output logic [DATA_W-1:0]         ram_wdata_out,
  input  logic [DATA_W-1:0]         ram_rdata_in,
  output logic                      idle_out
);
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STREAK_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(WR_BURST_MAX);

  logic [IDX_W-1:0]    rr_ptr;
  logic [STREAK_W-1:0] wr_streak;
  logic                any_rd;
  logic                wr_win;
  logic                rd_win;
  logic [IDX_W-1:0]    rd_idx;
  logic [ADDR_W-1:0]   req_addr [NUM_REQ];
  logic                stage_rd;
  logic [IDX_W-1:0]    stage_idx;
  logic [RAM_LATENCY-1:0] pipe_valid;
  logic [IDX_W-1:0]    pipe_idx [RAM_LATENCY];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign req_addr[g] = rd_addr_in[g*ADDR_W +: ADDR_W];
  end

  // A saturated write streak yields to any pending read.
  assign any_rd = |rd_valid_in;
  assign wr_win = wr_valid_in && !((wr_streak == BURST_MAX) && any_rd);
  assign rd_win = !wr_win && any_rd;

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found  = 1'b0;
    cand   = '0;
    rd_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && rd_valid_in[cand]) begin
        found  = 1'b1;
        rd_idx = cand;
      end
    end
  end

  assign rd_ready_out = rd_win ? (NUM_REQ'(1) << rd_idx) : '0;
  assign wr_ready_out = wr_win;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr        <= LAST_IDX;
      wr_streak     <= '0;
      ram_en_out    <= 1'b0;
      ram_we_out    <= 1'b0;
      ram_addr_out  <= '0;
      ram_wdata_out <= '0;
      stage_rd      <= 1'b0;
      stage_idx     <= '0;
      pipe_valid    <= '0;
      for (int s = 0; s < RAM_LATENCY; s++) pipe_idx[s] <= '0;
    end else begin
      ram_en_out <= wr_win || rd_win;
      ram_we_out <= wr_win;
      stage_rd   <= rd_win;
      if (wr_win) begin
        wr_streak     <= (wr_streak == BURST_MAX) ? wr_streak : wr_streak + 1'b1;
        ram_addr_out  <= wr_addr_in;
        ram_wdata_out <= wr_data_in;
      end else begin
        wr_streak <= '0;
        if (rd_win) begin
          rr_ptr       <= rd_idx;
          ram_addr_out <= req_addr[rd_idx];
          stage_idx    <= rd_idx;
        end
      end
      // Read tags trail the RAM stage by the RAM's own latency.
      pipe_valid[0] <= stage_rd;
      pipe_idx[0]   <= stage_idx;
      for (int s = 1; s < RAM_LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_idx[s]   <= pipe_idx[s-1];
      end
    end
  end

  assign rsp_valid_out = pipe_valid[RAM_LATENCY-1] ? (NUM_REQ'(1) << pipe_idx[RAM_LATENCY-1]) : '0;
  assign rsp_data_out  = ram_rdata_in;
  assign idle_out      = !stage_rd && !(|pipe_valid);
endmodule
`default_nettype wire

// File: tb/tb_voxel_ram_arbiter.sv
`default_nettype none
// Bench for voxel_ram_arbiter: directed and random traffic against a transaction-level
// model, with a response scoreboard drained by an independent monitor.
module tb_voxel_ram_arbiter;
  localparam int N = 4, AW = 16, DW = 5, LAT = 2, WB = 8;

  typedef struct { int idx; logic [DW-1:0] data; int cyc; } rsp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    rd_valid = '0;
  logic [AW-1:0]   ra [N];
  logic [N*AW-1:0] rd_addr_bus;
  logic [N-1:0]    rd_ready, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            wr_valid = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_ready, ram_en, ram_we, idle;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  int checks = 0, errors = 0, cyc = 0;

  voxel_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT),
                      .WR_BURST_MAX(WB)) dut (
    .clk_in(clk), .rst_in(rst_n), .rd_valid_in(rd_valid), .rd_addr_in(rd_addr_bus),
    .rd_ready_out(rd_ready), .rsp_valid_out(rsp_valid), .rsp_data_out(rsp_data),
    .wr_valid_in(wr_valid), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .wr_ready_out(wr_ready), .ram_en_out(ram_en), .ram_we_out(ram_we),
    .ram_addr_out(ram_addr), .ram_wdata_out(ram_wdata), .ram_rdata_in(ram_rdata),
    .idle_out(idle));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rd_addr_bus = '0;
    for (int i = 0; i < N; i++) rd_addr_bus[i*AW +: AW] = ra[i];
  end

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(a ^ (a >> 5) ^ (a >> 10));
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural single-port RAM, two-cycle read latency.
  logic [DW-1:0] mem [65536];
  initial begin
    logic en, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, s1;
    for (int i = 0; i < 65536; i++) mem[i] = init_val(AW'(i));
    s1 = '0;
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      en = ram_en; we = ram_we; a = ram_addr; d = ram_wdata;
      @(posedge clk);
      ram_rdata = s1;
      if (en && we) mem[a] = d;
      else if (en) s1 = mem[a];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [65536];
  rsp_t          sb [$];
  int            fl [$];
  int            rr = N - 1, streak = 0;
  logic          pend_en = 1'b0, pend_we = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_wd = '0;
  int            wait_c [N];
  int            max_wait [N];
  logic [N-1:0]  keep_rd = '0, acc_rd = '0;
  logic          keep_wr = 1'b0, acc_wr = 1'b0, rand_on = 1'b0;

  task automatic check_cycle();
    logic [N-1:0] exp_rd;
    logic         exp_wr, idle_exp;
    int           g;
    chk("ram_en", 32'(ram_en), 32'(pend_en));
    chk("ram_we", 32'(ram_we), 32'(pend_en && pend_we));
    if (pend_en) chk("ram_addr", 32'(ram_addr), 32'(pend_addr));
    if (pend_en && pend_we) chk("ram_wdata", 32'(ram_wdata), 32'(pend_wd));
    while (fl.size() > 0 && fl[0] < cyc) void'(fl.pop_front());
    idle_exp = 1'b1;
    foreach (fl[k]) if (fl[k] - LAT <= cyc) idle_exp = 1'b0;
    chk("idle", 32'(idle), 32'(idle_exp));

    exp_rd = '0; exp_wr = 1'b0; g = -1;
    if (wr_valid && !(streak == WB && rd_valid != 0)) begin
      exp_wr = 1'b1;
      if (streak < WB) streak++;
    end else begin
      streak = 0;
      for (int k = 1; k <= N; k++)
        if (g < 0 && rd_valid[(rr + k) % N]) g = (rr + k) % N;
      if (g >= 0) begin
        exp_rd[g] = 1'b1;
        rr = g;
      end
    end
    chk("rd_ready", 32'(rd_ready), 32'(exp_rd));
    chk("wr_ready", 32'(wr_ready), 32'(exp_wr));

    if (exp_wr) begin
      ref_mem[wr_addr] = wr_data;
      pend_en = 1'b1; pend_we = 1'b1; pend_addr = wr_addr; pend_wd = wr_data;
    end else if (g >= 0) begin
      sb.push_back('{g, ref_mem[ra[g]], cyc + 1 + LAT});
      fl.push_back(cyc + 1 + LAT);
      pend_en = 1'b1; pend_we = 1'b0; pend_addr = ra[g];
    end else begin
      pend_en = 1'b0; pend_we = 1'b0;
    end

    for (int i = 0; i < N; i++) begin
      if (rd_valid[i]) begin
        wait_c[i]++;
        if (exp_rd[i]) begin
          chk("rd_wait_bound", 32'(wait_c[i] <= N * (WB + 1)), 32'd1);
          if (wait_c[i] > max_wait[i]) max_wait[i] = wait_c[i];
          wait_c[i] = 0;
        end
      end else wait_c[i] = 0;
    end
    acc_rd = rd_valid & rd_ready;
    acc_wr = wr_valid & wr_ready;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (acc_rd[i]) begin rd_valid[i] = keep_rd[i]; ra[i] = rnd_addr(); end
    if (acc_wr) begin wr_valid = keep_wr; wr_addr = rnd_addr(); wr_data = DW'($urandom); end
    if (rand_on) begin
      for (int i = 0; i < N; i++)
        if (!rd_valid[i] && $urandom_range(0, 2) == 0) begin rd_valid[i] = 1'b1; ra[i] = rnd_addr(); end
      if (!wr_valid && $urandom_range(0, 1) == 0) begin
        wr_valid = 1'b1; wr_addr = rnd_addr(); wr_data = DW'($urandom);
      end
    end
  endtask

  task automatic drain();
    int n;
    rand_on = 1'b0; keep_rd = '0; keep_wr = 1'b0; n = 0;
    while ((rd_valid != 0 || wr_valid) && n < 200) begin tick(); n++; end
    if (n >= 200) chk("drain_timeout", 32'(n), 32'd0);
    repeat (LAT + 3) tick();
  endtask

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("rsp_missing", 32'(cyc), 32'(e.cyc));
      end
      if (rsp_valid != 0) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(AW'(i));
    for (int i = 0; i < N; i++) begin ra[i] = '0; wait_c[i] = 0; max_wait[i] = 0; end
    repeat (2) @(negedge clk);
    chk("rst_rd_ready", 32'(rd_ready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'(ram_rdata));
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // single read from requester 2
    rd_valid[2] = 1'b1; ra[2] = 16'h0123;
    drain();

    // all readers saturated
    keep_rd = 4'hF; rd_valid = 4'hF;
    repeat (16) tick();
    drain();

    // writer held against reader 1
    max_wait[1] = 0;
    keep_rd = 4'b0010; rd_valid = 4'b0010;
    keep_wr = 1'b1; wr_valid = 1'b1; wr_addr = rnd_addr(); wr_data = DW'($urandom);
    repeat (45) tick();
    drain();
    chk("burst_read_wait", 32'(max_wait[1]), 32'(WB + 1));

    // read-after-write to the same address
    wr_valid = 1'b1; wr_addr = 16'h0040; wr_data = 5'h1F;
    tick();
    rd_valid[3] = 1'b1; ra[3] = 16'h0040;
    drain();

    // random mixed traffic
    rand_on = 1'b1;
    repeat (1500) tick();
    drain();

    // reset with reads in flight
    keep_rd = 4'b0011; rd_valid = 4'b0011;
    tick(); tick();
    rst_n = 1'b0; rd_valid = '0; keep_rd = '0; wr_valid = 1'b0;
    sb.delete(); fl.delete();
    rr = N - 1; streak = 0; pend_en = 1'b0; pend_we = 1'b0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    chk("midrst_ram_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) tick();
    rd_valid = 4'hF;
    for (int i = 0; i < N; i++) ra[i] = rnd_addr();
    tick();
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/voxel_ram_arbiter.md
# voxel_ram_arbiter

Single-port arbiter sharing the voxel world RAM (the L3 cache storage, 64×64×16 blocks) between NUM_REQ voxel traversal unit read ports and one world-update write port fed by the UART loader. It grants at most one RAM access per cycle, with two rules:
- Writes have priority, bounded by a starvation limit so pending reads still make progress.
- Reads are round-robin among the traversal units.

Each read's data is returned to its requester after a fixed latency.

## Interface
Parameters:
- NUM_REQ, 4, number of read requesters (traversal units)
- ADDR_W, 16, block address width (x,y,z flattened; 65536 blocks)
- DATA_W, 5, block data width (BlockType)
- RAM_LATENCY, 2, RAM read latency in cycles from ram_en to valid ram_rdata
- WR_BURST_MAX, 8, max consecutive write grants while a read is pending

Ports:
- clk_in  in  1  system clock; everything is synchronous to this one clock
- rst_in  in  1  reset, asynchronous, active-low
- rd_valid_in  in  NUM_REQ  read request per requester
- rd_addr_in  in  NUM_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
- rd_ready_out  out  NUM_REQ  read accept, one-hot or zero
- rsp_valid_out  out  NUM_REQ  read data valid for requester i, one-hot or zero
- rsp_data_out  out  DATA_W  read data, shared by all requesters
- wr_valid_in  in  1  write request
- wr_addr_in  in  ADDR_W  write address
- wr_data_in  in  DATA_W  write data
- wr_ready_out  out  1  write accept
- ram_en_out  out  1  RAM access enable
- ram_we_out  out  1  RAM write enable
- ram_addr_out  out  ADDR_W  RAM address
- ram_wdata_out  out  DATA_W  RAM write data
- ram_rdata_in  in  DATA_W  RAM read data
- idle_out  out  1  high when no read is in flight

## Operation
Handshake:
- A transfer occurs on a port in a cycle where its valid and ready are both high.
- A requester holds valid and addr stable until ready.
- Ready is combinational from valid and arbiter state. Requesters must not make valid depend on ready.

Arbitration, evaluated every cycle, exactly one winner:
- If wr_valid_in is high and not (wr_streak == WR_BURST_MAX and any rd_valid_in is high): write wins. wr_ready_out=1. wr_streak increments, saturating at WR_BURST_MAX.
- Else, if any rd_valid_in is high: read wins.
  - Search for the first valid requester starting at rr_ptr+1 modulo NUM_REQ.
  - rd_ready_out[i]=1 for that requester only.
  - rr_ptr updates to i. wr_streak resets to 0.
- Else no grant. wr_streak resets to 0 when wr_valid_in is low.

Registered RAM stage:
- On a granted transfer, the next cycle drives ram_en_out=1, ram_addr_out, and ram_we_out / ram_wdata_out for a write.
- Otherwise ram_en_out=0 and ram_we_out=0.

Response pipeline:
- A shift register of depth RAM_LATENCY carries {valid, requester index} for reads.
- At the output, rsp_valid_out[index]=valid. rsp_data_out = ram_rdata_in, passed through combinationally.
- Responses return in grant order. There is no backpressure: requesters must accept rsp_valid_out unconditionally.

Ordering:
- One RAM operation per cycle, in grant order.
- A read granted after a write to the same address returns the new data, whatever the RAM's read-during-write mode.

Status:
- idle_out = no valid entry in the response pipeline and no read registered in the RAM stage.

## Timing
- Reset values: rd_ready_out=0, wr_ready_out=0, rsp_valid_out=0, rsp_data_out follows ram_rdata_in, ram_en_out=0, ram_we_out=0, ram_addr_out=0, ram_wdata_out=0, idle_out=1, rr_ptr=NUM_REQ-1 (requester 0 is served first), wr_streak=0.
- Assertion of rst_in mid-operation discards all in-flight reads; no rsp_valid_out follows.
- Read accepted at clock edge T: ram_en_out is high in cycle T+1, and rsp_valid_out is high in cycle T+1+RAM_LATENCY. Total latency is RAM_LATENCY+1 cycles.
- Write accepted at edge T: ram_we_out is high in cycle T+1.
- Throughput is one access per cycle, sustained back-to-back.
- Under saturated contention, each active reader is guaranteed a grant within NUM_REQ*(WR_BURST_MAX+1) cycles.
- When wr_valid_in is held high and a read is pending: WR_BURST_MAX writes, then 1 read, repeating.

## Test plan
- Reset with all requests low -> all outputs at reset values, idle_out=1. Then rd_valid_in[2]=1, addr=0x0123 -> rd_ready_out=4'b0100 same cycle, ram_addr_out=0x0123 next cycle, rsp_valid_out=4'b0100 three cycles after accept with rsp_data_out equal to the RAM model content.
- All four readers held valid, no writes -> grants cycle 0,1,2,3,0,... on consecutive cycles, and responses return in the same order with matching data.
- wr_valid_in held high, reader 1 held valid, WR_BURST_MAX=8 -> 8 write grants, then 1 read grant, repeating. Reader 1 is never waiting more than 9 cycles.
- Write 0x1F to addr 0x0040, then read addr 0x0040 on the following cycle -> read returns 0x1F.
- Assert rst_in low while 2 reads are in flight -> no rsp_valid_out pulses afterward, idle_out=1, and the next grant goes to requester 0.
